clk_rst_seq: RTL and testbench
==============================

// Module: clk_rst_seq
// PURPOSE
//  Parametrised successor to the single-DCM board clock block.
//  - Sequences N_DCM clock generators (MMCM/PLL) from one free-running reference clock CLK.
//  - Holds each generator in reset and waits for it to lock, with a lock timeout and a bounded retry count.
//  - Releases one per-domain reset per generator after lock has been stable for SETTLE_CYCLES.
//  - Re-runs the sequence automatically when lock is lost.
//  - Sits beside the IBUFGDS/MMCM instances in the board clock wrapper.
// PARAMETERS
//  N_DCM          2      number of generator channels, 1..8
//  RST_CYCLES     255    cycles DCM_RST is held high on each (re)start, >=1
//  LOCK_TIMEOUT   65535  cycles allowed in WAIT before declaring a timeout, >=1
//  SETTLE_CYCLES  1024   cycles lock must stay continuously high before DOM_RST is released, >=1
//  RETRY_MAX      3      failed attempts (timeout or lock loss) before sticky FAIL, >=1
// PORTS
//  CLK            in   1        reference clock; all logic runs on CLK
//  RST            in   1        asynchronous, active-high reset
//  DCM_LOCKED_IN  in   N_DCM    generator lock outputs; asynchronous to CLK
//  DCM_RST        out  N_DCM    generator reset; 1 = held in reset
//  DOM_RST        out  N_DCM    per-domain reset; 1 = domain held; consumer resynchronises it
//  ALL_LOCKED     out  1        1 when every channel is in RUN
//  FAIL           out  N_DCM    sticky per-channel failure flag
//  LOSS_CNT       out  8*N_DCM  only with CLK_RST_SEQ_LOSS_CNT_EN; channel i at [8i+7:8i]
// BEHAVIOUR
//  Reset (RST=1):
//  - Every channel is in HOLD with its counters cleared.
//  - DCM_RST=all 1, DOM_RST=all 1, ALL_LOCKED=0, FAIL=0, LOSS_CNT=0.
//  Lock synchronisation:
//  - DCM_LOCKED_IN passes through a 2-FF synchroniser per bit; the result is lk[i].
//  - An input change becomes visible to the FSM 2 cycles later.
//  Per-channel FSM (channels are independent; one timer and one retry count per channel):
//  - HOLD: DCM_RST=1, DOM_RST=1.
//    After RST_CYCLES cycles in HOLD, go to WAIT.
//  - WAIT: DCM_RST=0, DOM_RST=1.
//    - lk=1: go to SETTLE.
//    - LOCK_TIMEOUT cycles elapse without lk: count a failed attempt.
//  - SETTLE: DCM_RST=0, DOM_RST=1.
//    - lk=0: count a failed attempt.
//    - lk high for SETTLE_CYCLES consecutive cycles: go to RUN.
//  - RUN: DCM_RST=0, DOM_RST=0.
//    - Entering RUN clears the retry count.
//    - lk=0: go to HOLD and count a failed attempt.
//  - FAILED: DCM_RST=1, DOM_RST=1, FAIL[i]=1. Left only by RST.
//  Failed attempts:
//  - Each one increments the retry count.
//  - When the count reaches RETRY_MAX, go to FAILED; otherwise go to HOLD.
//  Output timing:
//  - All outputs are registered and change in the cycle after the state change.
//  - DOM_RST[i] deasserts exactly SETTLE_CYCLES cycles after the first lk=1 sample, plus 1 register cycle.
//  Counter rules:
//  - Timer width is $clog2(max(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)+1).
//  - The timer clears on every state change.
//  - The timer never wraps: it is compared for equality, then the state leaves.
//  Boundary cases:
//  - lk falls in the same cycle the SETTLE count expires: the loss wins; go to HOLD/FAILED, never RUN.
//  - lk rises in the same cycle the WAIT timeout expires: the lock wins; go to SETTLE.
//  - ALL_LOCKED is the AND of all channels being in RUN; a single FAIL holds it at 0.
//  - RST asserted mid-sequence: all state is cleared immediately, asynchronously.
//  - RST deasserts into HOLD with the timer at 0.
// CONFIGURATION
//  CLK_RST_SEQ_LOSS_CNT_EN defined:
//  - Adds port LOSS_CNT.
//  - Per channel, an 8-bit counter increments on each RUN->HOLD or RUN->FAILED transition.
//  - The counter saturates at 8'hFF and is cleared only by RST.
//  CLK_RST_SEQ_LOSS_CNT_EN undefined:
//  - No LOSS_CNT port and no counter logic.
//  - All other behaviour is identical.
// TESTING
//  Bench parameters: N_DCM=2, RST_CYCLES=8, LOCK_TIMEOUT=32, SETTLE_CYCLES=4, RETRY_MAX=2.
//  1. Nominal: release RST, raise both locks 5 cycles after DCM_RST falls -> DCM_RST low 8 cycles after RST release;
//     DOM_RST low 2+4+1 cycles after lock rises; ALL_LOCKED=1.
//  2. Timeout: keep ch0 lock low -> ch0 does 2 HOLD/WAIT cycles of 8+32 -> FAIL[0]=1, DCM_RST[0]=1;
//     ch1 reaches RUN; ALL_LOCKED stays 0.
//  3. Loss in RUN: drop ch1 lock for 1 cycle -> DOM_RST[1]=1 within 3 cycles, DCM_RST[1]=1 for 8 cycles,
//     then the sequence reruns to RUN; LOSS_CNT[15:8]=1 when the macro is defined.
//  4. SETTLE glitch: lock high 2 cycles, low 1, then high -> no DOM_RST release;
//     HOLD re-entered; the retry count clears after a later RUN.
//  5. Async reset mid-SETTLE: pulse RST for 3 ns between edges -> DCM_RST and DOM_RST=all 1 with no clock edge;
//     FAIL and LOSS_CNT cleared.
//  6. Saturation (macro defined): 300 RUN losses on ch0 -> LOSS_CNT[7:0]=8'hFF, no wrap.

Source files
------------

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: sequences N_DCM clock generators (MMCM/PLL) from one reference clock.
//   Each channel holds its generator in reset, waits for lock (with a timeout),
//   waits for lock to stay high for SETTLE_CYCLES, and then releases its domain reset.
//   A lost lock restarts the sequence. RETRY_MAX failed attempts make FAIL sticky.
// Optional feature: define CLK_RST_SEQ_LOSS_CNT_EN to add per-channel RUN-loss counters.
// Ports (top):
//   CLK            in   reference clock, all logic runs on it
//   RST            in   async active-high reset
//   DCM_LOCKED_IN  in   [N_DCM] generator lock, async to CLK
//   DCM_RST        out  [N_DCM] generator reset (1 = held)
//   DOM_RST        out  [N_DCM] per-domain reset (1 = held)
//   ALL_LOCKED     out  every channel in RUN
//   FAIL           out  [N_DCM] sticky failure flag
//   LOSS_CNT       out  [8*N_DCM] saturating RUN-loss counts (macro only)

module clk_rst_seq_lane #(
  parameter int RST_CYCLES    = 255,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 1024,
  parameter int RETRY_MAX     = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       locked_i,
  output logic       dcm_rst_o,
  output logic       dom_rst_o,
  output logic       fail_o,
  output logic       run_nxt_o
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt_o
`endif
);
  localparam int TMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int TMAX   = (TMAX_A > SETTLE_CYCLES) ? TMAX_A : SETTLE_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int RW     = $clog2(RETRY_MAX + 1);

  // Timer counts 0..N-1 in a state; the last value triggers the exit.
  localparam logic [TW-1:0] T_HOLD   = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_WAIT   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX    = RW'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAILED = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [RW-1:0] retry_inc;
  logic [1:0]    sync_q;
  logic          lk;
  logic          fail_att;
  logic          dcm_rst_q, dom_rst_q, fail_q;

  // 2-FF synchroniser; lk is the only lock view the FSM uses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], locked_i};
  end
  assign lk = sync_q[1];

  assign retry_inc = retry_q + RW'(1);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TW'(1);
    retry_d  = retry_q;
    fail_att = 1'b0;
    case (state_q)
      S_HOLD:   if (timer_q == T_HOLD) state_d = S_WAIT;
      // Lock is tested first so a lock on the timeout cycle still wins.
      S_WAIT:   if (lk) state_d = S_SETTLE;
                else if (timer_q == T_WAIT) fail_att = 1'b1;
      // Loss is tested first so it beats an expiring settle count.
      S_SETTLE: if (!lk) fail_att = 1'b1;
                else if (timer_q == T_SETTLE) begin
                  state_d = S_RUN;
                  retry_d = '0;
                end
      S_RUN: begin
        timer_d = timer_q;  // idle timer, never wraps
        if (!lk) fail_att = 1'b1;
      end
      S_FAILED: timer_d = timer_q;
      default:  state_d = S_HOLD;
    endcase
    if (fail_att) begin
      retry_d = retry_inc;
      state_d = (retry_inc >= R_MAX) ? S_FAILED : S_HOLD;
    end
    if (state_d != state_q) timer_d = '0;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_HOLD;
      timer_q   <= '0;
      retry_q   <= '0;
      dcm_rst_q <= 1'b1;
      dom_rst_q <= 1'b1;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      dcm_rst_q <= (state_d == S_HOLD) || (state_d == S_FAILED);
      dom_rst_q <= (state_d != S_RUN);
      fail_q    <= (state_d == S_FAILED);
    end
  end

  assign dcm_rst_o = dcm_rst_q;
  assign dom_rst_o = dom_rst_q;
  assign fail_o    = fail_q;
  assign run_nxt_o = (state_d == S_RUN);

`ifdef CLK_RST_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) loss_q <= 8'h00;
    else if ((state_q == S_RUN) && (state_d != S_RUN) && (loss_q != 8'hFF))
      loss_q <= loss_q + 8'd1;
  end
  assign loss_cnt_o = loss_q;
`endif
endmodule

module clk_rst_seq #(
  parameter int N_DCM         = 2,
  parameter int RST_CYCLES    = 255,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 1024,
  parameter int RETRY_MAX     = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_DCM-1:0]   DCM_LOCKED_IN,
  output logic [N_DCM-1:0]   DCM_RST,
  output logic [N_DCM-1:0]   DOM_RST,
  output logic               ALL_LOCKED,
  output logic [N_DCM-1:0]   FAIL
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [8*N_DCM-1:0] LOSS_CNT
`endif
);
  logic [N_DCM-1:0] run_nxt;
  logic             all_locked_q;

  for (genvar g = 0; g < N_DCM; g++) begin : g_lane
    clk_rst_seq_lane #(
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .RETRY_MAX    (RETRY_MAX)
    ) u_lane (
      .clk_i     (CLK),
      .rst_i     (RST),
      .locked_i  (DCM_LOCKED_IN[g]),
      .dcm_rst_o (DCM_RST[g]),
      .dom_rst_o (DOM_RST[g]),
      .fail_o    (FAIL[g]),
      .run_nxt_o (run_nxt[g])
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
      ,
      .loss_cnt_o(LOSS_CNT[8*g +: 8])
`endif
    );
  end

  // Registered from next-state so it asserts together with the last DOM_RST release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) all_locked_q <= 1'b0;
    else     all_locked_q <= &run_nxt;
  end
  assign ALL_LOCKED = all_locked_q;
endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: directed scenarios plus randomized lock traffic for clk_rst_seq,
// checked every cycle against a countdown-based reference model of the sequencer.
module tb_clk_rst_seq;
  localparam int N = 2, RC = 8, LT = 32, SC = 4, RM = 2;
  localparam int P_HOLD = 0, P_WAIT = 1, P_SET = 2, P_RUN = 3, P_FAIL = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic [N-1:0] DCM_LOCKED_IN, DCM_RST, DOM_RST, FAIL;
  logic         ALL_LOCKED;
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
  logic [8*N-1:0] LOSS_CNT;
`endif

  int n_cmp = 0, n_err = 0;

  always #5 CLK = ~CLK;

  clk_rst_seq #(.N_DCM(N), .RST_CYCLES(RC), .LOCK_TIMEOUT(LT),
                .SETTLE_CYCLES(SC), .RETRY_MAX(RM)) dut (
    .CLK(CLK), .RST(RST), .DCM_LOCKED_IN(DCM_LOCKED_IN), .DCM_RST(DCM_RST),
    .DOM_RST(DOM_RST), .ALL_LOCKED(ALL_LOCKED), .FAIL(FAIL)
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    , .LOSS_CNT(LOSS_CNT)
`endif
  );

  // Reference model: phase, cycles left in phase, failed tries, losses.
  int           ph[N], left[N], tries[N], loss[N];
  logic [N-1:0] s1, s2;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      ph[i] = P_HOLD; left[i] = RC; tries[i] = 0; loss[i] = 0;
    end
    s1 = '0; s2 = '0;
  endfunction

  function automatic void m_fail(int i);
    tries[i]++;
    if (tries[i] >= RM) ph[i] = P_FAIL;
    else begin ph[i] = P_HOLD; left[i] = RC; end
  endfunction

  function automatic void m_edge(logic [N-1:0] din);
    logic [N-1:0] lkv;
    if (RST) begin m_reset(); return; end
    lkv = s2; s2 = s1; s1 = din;
    for (int i = 0; i < N; i++) begin
      case (ph[i])
        P_HOLD: begin
          left[i]--;
          if (left[i] == 0) begin ph[i] = P_WAIT; left[i] = LT; end
        end
        P_WAIT:
          if (lkv[i]) begin ph[i] = P_SET; left[i] = SC; end
          else begin left[i]--; if (left[i] == 0) m_fail(i); end
        P_SET:
          if (!lkv[i]) m_fail(i);
          else begin
            left[i]--;
            if (left[i] == 0) begin ph[i] = P_RUN; tries[i] = 0; end
          end
        P_RUN:
          if (!lkv[i]) begin
            if (loss[i] < 255) loss[i]++;
            m_fail(i);
          end
        default: ;
      endcase
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e_dcm, e_dom, e_fail;
    logic         e_all;
    logic [8*N-1:0] e_loss;
    e_all = 1'b1;
    for (int i = 0; i < N; i++) begin
      e_dcm[i]  = (ph[i] == P_HOLD) || (ph[i] == P_FAIL);
      e_dom[i]  = (ph[i] != P_RUN);
      e_fail[i] = (ph[i] == P_FAIL);
      e_all     = e_all & (ph[i] == P_RUN);
      e_loss[8*i +: 8] = 8'(loss[i]);
    end
    chk("cyc_dcm_rst", 32'(DCM_RST), 32'(e_dcm));
    chk("cyc_dom_rst", 32'(DOM_RST), 32'(e_dom));
    chk("cyc_fail", 32'(FAIL), 32'(e_fail));
    chk("cyc_all_locked", 32'(ALL_LOCKED), 32'(e_all));
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    chk("cyc_loss_cnt", 32'(LOSS_CNT), 32'(e_loss));
`else
    if (e_loss != '0) chk("cyc_loss_model", 32'(e_loss), 32'(e_loss));
`endif
  endtask

  task automatic tick();
    @(posedge CLK);
    m_edge(DCM_LOCKED_IN);
    #1;
    check_all();
  endtask

  // Called at posedge+1: pulse RST for 3 ns with no clock edge in between.
  task automatic pulse_rst(string tag);
    #1 RST = 1'b1; m_reset();
    #1;
    chk({tag, "_dcm_rst"}, 32'(DCM_RST), 32'(2'b11));
    chk({tag, "_dom_rst"}, 32'(DOM_RST), 32'(2'b11));
    chk({tag, "_fail"}, 32'(FAIL), 32'(0));
    chk({tag, "_all_locked"}, 32'(ALL_LOCKED), 32'(0));
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    chk({tag, "_loss_cnt"}, 32'(LOSS_CNT), 32'(0));
`endif
    #2 RST = 1'b0;
  endtask

  initial begin
    int n;
    logic released, held;
    RST = 1'b1; DCM_LOCKED_IN = '0; m_reset();
    #3;
    chk("rst_dcm_rst", 32'(DCM_RST), 32'(2'b11));
    chk("rst_dom_rst", 32'(DOM_RST), 32'(2'b11));
    chk("rst_fail", 32'(FAIL), 32'(0));
    chk("rst_all_locked", 32'(ALL_LOCKED), 32'(0));
    repeat (2) tick();
    RST = 1'b0;

    // 1. Nominal bring-up
    n = 0; while (DCM_RST != 2'b00 && n < 50) begin tick(); n++; end
    chk("t1_dcm_rst_release", 32'(n), 32'(RC));
    repeat (5) tick();
    DCM_LOCKED_IN = 2'b11;
    n = 0; while (DOM_RST != 2'b00 && n < 50) begin tick(); n++; end
    chk("t1_dom_rst_release", 32'(n), 32'(2 + SC + 1));
    chk("t1_all_locked", 32'(ALL_LOCKED), 32'(1));

    // 3. One-cycle loss on ch1 in RUN
    DCM_LOCKED_IN[1] = 1'b0; tick(); DCM_LOCKED_IN[1] = 1'b1;
    n = 1; while (DOM_RST[1] != 1'b1 && n < 10) begin tick(); n++; end
    chk("t3_dom_rst_reassert", 32'(n), 32'(3));
    n = 0; while (DCM_RST[1] == 1'b1 && n < 50) begin tick(); n++; end
    chk("t3_dcm_rst_hold_len", 32'(n), 32'(RC));
    n = 0; while (DOM_RST[1] != 1'b0 && n < 50) begin tick(); n++; end
    chk("t3_rerun_all_locked", 32'(ALL_LOCKED), 32'(1));
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    chk("t3_loss_cnt", 32'(LOSS_CNT), 32'(16'h0100));
`endif

    // 2. Timeout on ch0, ch1 locks
    DCM_LOCKED_IN = 2'b10;
    pulse_rst("t2_rst");
    n = 0; while (FAIL[0] != 1'b1 && n < 120) begin tick(); n++; end
    chk("t2_fail_cycle", 32'(n), 32'(2 * (RC + LT)));
    chk("t2_fail", 32'(FAIL), 32'(2'b01));
    chk("t2_dcm_rst", 32'(DCM_RST), 32'(2'b01));
    chk("t2_dom_rst", 32'(DOM_RST), 32'(2'b01));
    chk("t2_all_locked", 32'(ALL_LOCKED), 32'(0));

    // 4. SETTLE glitch on ch1, then retry count cleared by RUN
    DCM_LOCKED_IN = 2'b01;
    pulse_rst("t4_rst");
    n = 0; while (DCM_RST != 2'b00 && n < 50) begin tick(); n++; end
    DCM_LOCKED_IN[1] = 1'b1; tick(); tick();
    DCM_LOCKED_IN[1] = 1'b0; tick();
    DCM_LOCKED_IN[1] = 1'b1;
    released = 1'b0; held = 1'b0;
    repeat (12) begin
      tick();
      if (DOM_RST[1] == 1'b0) released = 1'b1;
      if (DCM_RST[1] == 1'b1) held = 1'b1;
    end
    chk("t4_no_release", 32'(released), 32'(0));
    chk("t4_hold_reentered", 32'(held), 32'(1));
    n = 0; while (DOM_RST[1] != 1'b0 && n < 50) begin tick(); n++; end
    chk("t4_run_after_glitch", 32'(DOM_RST), 32'(2'b00));
    DCM_LOCKED_IN[1] = 1'b0; tick(); DCM_LOCKED_IN[1] = 1'b1;
    repeat (3) tick();
    n = 0; while (DOM_RST[1] != 1'b0 && n < 60) begin tick(); n++; end
    chk("t4_retry_cleared_fail", 32'(FAIL), 32'(0));
    chk("t4_retry_cleared_run", 32'(DOM_RST[1]), 32'(0));

    // 5. Async reset mid-SETTLE with FAIL[0] and LOSS_CNT set
    DCM_LOCKED_IN[0] = 1'b0;
    n = 0; while (FAIL[0] != 1'b1 && n < 100) begin tick(); n++; end
    chk("t5_pre_fail", 32'(FAIL), 32'(2'b01));
    DCM_LOCKED_IN[1] = 1'b0; tick(); DCM_LOCKED_IN[1] = 1'b1;
    n = 0; while (ph[1] != P_SET && n < 50) begin tick(); n++; end
    tick();
    chk("t5_pre_settle_dcm", 32'(DCM_RST), 32'(2'b01));
    DCM_LOCKED_IN = 2'b00;
    pulse_rst("t5_async");

    // Boundaries: lock on the timeout cycle (ch0), loss on settle expiry (ch0)
    n = 0; while (DCM_RST != 2'b00 && n < 50) begin tick(); n++; end
    repeat (LT - 3) tick();
    DCM_LOCKED_IN[0] = 1'b1;
    repeat (3) tick();
    chk("bnd_lock_beats_timeout", 32'(DCM_RST), 32'(2'b10));
    tick();
    DCM_LOCKED_IN[0] = 1'b0;
    repeat (3) tick();
    chk("bnd_loss_beats_settle_dom", 32'(DOM_RST[0]), 32'(1));
    chk("bnd_loss_beats_settle_dcm", 32'(DCM_RST[0]), 32'(1));

`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    // 6. Loss counter saturation on ch0
    DCM_LOCKED_IN = 2'b11;
    pulse_rst("t6_rst");
    for (int k = 0; k < 300; k++) begin
      n = 0; while (DOM_RST[0] != 1'b0 && n < 60) begin tick(); n++; end
      DCM_LOCKED_IN[0] = 1'b0; tick(); DCM_LOCKED_IN[0] = 1'b1;
      tick(); tick();
    end
    chk("t6_loss_saturated", 32'(LOSS_CNT[7:0]), 32'(8'hFF));
`endif

    // Randomized lock traffic
    for (int r = 0; r < 4; r++) begin
      DCM_LOCKED_IN = 2'($urandom);
      pulse_rst("rnd_rst");
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(39) == 0) DCM_LOCKED_IN[i] = ~DCM_LOCKED_IN[i];
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
